// File: rtl/float_mac_pipe.sv
// float_mac_pipe -- pipelined mini-float dot-product accumulator.
//
// Each beat carries LANES pairs of tiny floats {sign, exp, frac} (no bias,
// implicit bit = OR of exponent). Each lane product is turned into a signed
// fixed-point term, the lane terms are summed, and the sum is accumulated
// until a beat marked in_last completes the dot product.
//
// Pipeline (all stages move together on adv = !out_valid || out_ready):
//   S0 input capture  -> S1 products/exp sums/signs -> S2 lane sum -> S3 acc.
//   A beat accepted at edge t reaches the accumulator at edge t+3.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   a, b               packed lane operands, lane i at [i*W +: W]
//   in_valid, in_last  beat present / final beat of a dot product
//   in_ready           beat accepted when in_valid && in_ready
//   data_out, ovf_out  signed result and overflow flag for the dot product
//   out_valid          result present; held stable until out_ready
//   out_ready          consumer takes the result
//
// Build option: define FLOAT_MAC_PIPE_SAT_EN to clamp the accumulator on
// overflow instead of wrapping modulo 2^ACC_WIDTH.
//
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds its payload stable while valid is high and ready is low.
module float_mac_pipe #(
    parameter int EXP_A     = 3,
    parameter int FRAC_A    = 2,
    parameter int EXP_B     = 3,
    parameter int FRAC_B    = 2,
    parameter int LANES     = 2,
    parameter int ACC_WIDTH = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [LANES*(1+EXP_A+FRAC_A)-1:0]  a,
    input  logic [LANES*(1+EXP_B+FRAC_B)-1:0]  b,
    input  logic                               in_valid,
    input  logic                               in_last,
    output logic                               in_ready,
    output logic [ACC_WIDTH-1:0]               data_out,
    output logic                               ovf_out,
    output logic                               out_valid,
    input  logic                               out_ready
);
    localparam int WA = 1 + EXP_A + FRAC_A;
    localparam int WB = 1 + EXP_B + FRAC_B;
    localparam int PW = FRAC_A + FRAC_B + 2;
    localparam int EW = ((EXP_A > EXP_B) ? EXP_A : EXP_B) + 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int SW = ACC_WIDTH + LW;

    logic adv;

    // Stage registers
    logic                   s0_valid_q, s0_last_q;
    logic [LANES*WA-1:0]    s0_a_q;
    logic [LANES*WB-1:0]    s0_b_q;
    logic                   s1_valid_q, s1_last_q;
    logic [PW-1:0]          s1_prod_q [LANES];
    logic [EW-1:0]          s1_exp_q  [LANES];
    logic                   s1_sign_q [LANES];
    logic                   s2_valid_q, s2_last_q;
    logic [SW-1:0]          s2_sum_q;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic                   sticky_q;
    logic [ACC_WIDTH-1:0]   data_out_q;
    logic                   ovf_out_q;
    logic                   out_valid_q;

    // Next-state values
    logic [PW-1:0]          s1_prod_d [LANES];
    logic [EW-1:0]          s1_exp_d  [LANES];
    logic                   s1_sign_d [LANES];
    logic [SW-1:0]          s2_sum_d;
    logic [ACC_WIDTH-1:0]   acc_d;
    logic                   ovf_d;

    // Working values
    logic [FRAC_A:0]        op_a;
    logic [FRAC_B:0]        op_b;
    logic [ACC_WIDTH-1:0]   term;
    logic [SW:0]            full;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign data_out  = data_out_q;
    assign ovf_out   = ovf_out_q;
    assign out_valid = out_valid_q;

    // S1: per-lane unsigned significand product, unbiased exponent sum, sign.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < LANES; i++) begin
            op_a = {|s0_a_q[i*WA+FRAC_A +: EXP_A], s0_a_q[i*WA +: FRAC_A]};
            op_b = {|s0_b_q[i*WB+FRAC_B +: EXP_B], s0_b_q[i*WB +: FRAC_B]};
            s1_prod_d[i] = {{(FRAC_B+1){1'b0}}, op_a} * {{(FRAC_A+1){1'b0}}, op_b};
            s1_exp_d[i]  = {{(EW-EXP_A){1'b0}}, s0_a_q[i*WA+FRAC_A +: EXP_A]}
                         + {{(EW-EXP_B){1'b0}}, s0_b_q[i*WB+FRAC_B +: EXP_B]};
            s1_sign_d[i] = s0_a_q[i*WA+WA-1] ^ s0_b_q[i*WB+WB-1];
        end
    end

    // S2: each term is negated before the shift, then sign-extended into the
    // wider lane-sum width so the lane sum itself cannot wrap.
    always_comb begin
        s2_sum_d = '0;
        term     = '0;
        for (int i = 0; i < LANES; i++) begin
            term = ACC_WIDTH'(s1_prod_q[i]);
            if (s1_sign_q[i]) term = -term;
            term = term << s1_exp_q[i];
            s2_sum_d = s2_sum_d + SW'($signed(term));
        end
    end

    // S3: exact sum in SW+1 bits; overflow when the bits above the ACC_WIDTH
    // sign position are not a pure sign extension.
    always_comb begin
        full  = (SW+1)'($signed(acc_q)) + (SW+1)'($signed(s2_sum_q));
        ovf_d = (full[SW:ACC_WIDTH-1] != '0) && (full[SW:ACC_WIDTH-1] != '1);
`ifdef FLOAT_MAC_PIPE_SAT_EN
        if (ovf_d)
            acc_d = full[SW] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            acc_d = full[ACC_WIDTH-1:0];
`else
        acc_d = full[ACC_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s0_valid_q  <= 1'b0;
            s0_last_q   <= 1'b0;
            s0_a_q      <= '0;
            s0_b_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod_q[i] <= '0;
                s1_exp_q[i]  <= '0;
                s1_sign_q[i] <= 1'b0;
            end
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_sum_q    <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            data_out_q  <= '0;
            ovf_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            s0_valid_q <= in_valid;
            s0_last_q  <= in_last;
            s0_a_q     <= a;
            s0_b_q     <= b;
            s1_valid_q <= s0_valid_q;
            s1_last_q  <= s0_last_q;
            for (int i = 0; i < LANES; i++) begin
                s1_prod_q[i] <= s1_prod_d[i];
                s1_exp_q[i]  <= s1_exp_d[i];
                s1_sign_q[i] <= s1_sign_d[i];
            end
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_sum_q   <= s2_sum_d;
            // Bubbles leave acc and sticky untouched; a previous result that
            // was just consumed drops out_valid here.
            out_valid_q <= 1'b0;
            if (s2_valid_q) begin
                if (s2_last_q) begin
                    data_out_q  <= acc_d;
                    ovf_out_q   <= sticky_q | ovf_d;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    sticky_q    <= 1'b0;
                end else begin
                    acc_q    <= acc_d;
                    sticky_q <= sticky_q | ovf_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_float_mac_pipe.sv
// Directed bench for float_mac_pipe: a default instance plus an ACC_WIDTH=24
// instance sharing the same stimulus, used for the overflow case.
module tb_float_mac_pipe;
    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] a, b;
    logic        in_valid, in_last, out_ready;
    logic        in_ready, ovf_out, out_valid;
    logic signed [31:0] data_out;
    logic        in_ready24, ovf_out24, out_valid24;
    logic signed [23:0] data_out24;

    int total = 0;
    int bad   = 0;
    int cyc;
    int seen;

`ifdef FLOAT_MAC_PIPE_SAT_EN
    localparam logic signed [63:0] EXP_OVF24 = 64'sd8388607;
`else
    localparam logic signed [63:0] EXP_OVF24 = -64'sd7143424;
`endif

    float_mac_pipe dut (
        .clock(clock), .reset(reset), .a(a), .b(b),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .data_out(data_out), .ovf_out(ovf_out), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    float_mac_pipe #(.ACC_WIDTH(24)) dut24 (
        .clock(clock), .reset(reset), .a(a), .b(b),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready24),
        .data_out(data_out24), .ovf_out(ovf_out24), .out_valid(out_valid24),
        .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [5:0] fp(input logic s, input logic [2:0] e, input logic [1:0] f);
        return {s, e, f};
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Presents one beat; returns just after the edge that accepted it.
    task automatic beat(input logic [5:0] a1, input logic [5:0] a0,
                        input logic [5:0] b1, input logic [5:0] b0, input logic last);
        a        = {a1, a0};
        b        = {b1, b0};
        in_valid = 1'b1;
        in_last  = last;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Counts falling edges until out_valid; a timeout is a failed comparison.
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (out_valid !== 1'b1 && n < 20);
        chk("out_valid_seen", out_valid, 1);
    endtask

    initial begin
        reset     = 1'b1;
        a         = '0;
        b         = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_ovf_out", ovf_out, 0);
        chk("rst_in_ready", in_ready, 1);

        // Single beat: 4*4 << 2 = 64, edge t+3
        beat(6'd0, fp(0, 3'd1, 2'd0), 6'd0, fp(0, 3'd1, 2'd0), 1'b1);
        wait_out(cyc);
        chk("one_latency", cyc, 4);
        chk("one_data", data_out, 64);
        chk("one_ovf", ovf_out, 0);
        @(negedge clock);
        chk("one_valid_drop", out_valid, 0);

        // Two beats: +64 then -64 -> 0
        beat(6'd0, fp(0, 3'd1, 2'd0), 6'd0, fp(0, 3'd1, 2'd0), 1'b0);
        beat(6'd0, fp(1, 3'd1, 2'd0), 6'd0, fp(0, 3'd1, 2'd0), 1'b1);
        wait_out(cyc);
        chk("two_latency", cyc, 4);
        chk("two_data", data_out, 0);

        // Mixed lanes: 5*6<<3 = 240 and denormal -(3*4<<3) = -96 -> 144
        beat(fp(1, 3'd0, 2'd3), fp(0, 3'd2, 2'd1), fp(0, 3'd3, 2'd0), fp(0, 3'd1, 2'd2), 1'b1);
        wait_out(cyc);
        chk("mix_data", data_out, 144);
        chk("mix_ovf", ovf_out, 0);

        // Six beats of 2*802816 = 9633792: overflows 24 bits, fits 32 bits
        for (int i = 0; i < 6; i++)
            beat(fp(0, 3'd7, 2'd3), fp(0, 3'd7, 2'd3), fp(0, 3'd7, 2'd3), fp(0, 3'd7, 2'd3), i == 5);
        wait_out(cyc);
        chk("big32_data", data_out, 9633792);
        chk("big32_ovf", ovf_out, 0);
        chk("big24_valid", out_valid24, 1);
        chk("big24_data", data_out24, EXP_OVF24);
        chk("big24_ovf", ovf_out24, 1);

        // Next product starts from zero with the sticky flag cleared
        beat(6'd0, fp(0, 3'd1, 2'd0), 6'd0, fp(0, 3'd1, 2'd0), 1'b1);
        wait_out(cyc);
        chk("after24_data", data_out24, 64);
        chk("after24_ovf", ovf_out24, 0);

        // Stall: result held for 5 cycles, a waiting beat is not taken
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        beat(6'd0, fp(0, 3'd1, 2'd0), 6'd0, fp(0, 3'd1, 2'd0), 1'b1);
        wait_out(cyc);
        a        = {6'd0, fp(1, 3'd1, 2'd0)};
        b        = {6'd0, fp(0, 3'd1, 2'd0)};
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_data", data_out, 64);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_out(cyc);
        chk("stall_next_latency", cyc, 4);
        chk("stall_next_data", data_out, -64);

        // Reset one cycle after a non-last beat: nothing comes out
        beat(6'd0, fp(0, 3'd1, 2'd0), 6'd0, fp(0, 3'd1, 2'd0), 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid === 1'b1) seen++;
        end
        chk("abort_no_valid", seen, 0);
        chk("abort_in_ready", in_ready, 1);
        beat(6'd0, fp(0, 3'd1, 2'd0), 6'd0, fp(0, 3'd1, 2'd0), 1'b1);
        wait_out(cyc);
        chk("abort_next_data", data_out, 64);

        // Back-to-back single-beat products
        @(posedge clock);
        #1;
        beat(6'd0, fp(0, 3'd1, 2'd0), 6'd0, fp(0, 3'd1, 2'd0), 1'b1);
        beat(6'd0, fp(1, 3'd1, 2'd0), 6'd0, fp(0, 3'd1, 2'd0), 1'b1);
        wait_out(cyc);
        chk("b2b_first", data_out, 64);
        @(negedge clock);
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second", data_out, -64);
        @(negedge clock);
        chk("b2b_end_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
